// File: rtl/mcpu_core_fetch_seq_pkg.sv
// Shared fetch-core constants: sequencer state encoding and packet/PC widths.
package mcpu_core_fetch_seq_pkg;

  localparam int PC_W  = 28;
  localparam int PKT_W = 128;

  typedef enum logic [1:0] {
    SEQ_RESET  = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_BUBBLE = 2'd2,
    SEQ_HALT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mcpu_core_fetch_seq.sv
// Fetch sequencer: issues the packet PC stream to the fetch TLB stage, with
// flush redirect, post-flush bubbles and halt/resume.
//
// state      | meaning
// SEQ_RESET  | first cycle after reset, no offer
// SEQ_RUN    | offering pc_q to the TLB stage
// SEQ_BUBBLE | idle cycles after a flush, counted by bub_q
// SEQ_HALT   | stopped while halt_req is high, pc_q held
module mcpu_core_fetch_seq
  import mcpu_core_fetch_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VPC     = '0,
  parameter int              FLUSH_BUBBLES = 1
) (
  input  logic            clkrst_core_clk,
  input  logic            clkrst_core_rst_n,
  output logic            s2ft_readyout,
  input  logic            s2ft_readyin,
  output logic [PC_W-1:0] s2ft_out_virtpc,
  input  logic            pipe_flush,
  input  logic [PC_W-1:0] flush_virtpc,
  input  logic            halt_req,
  output logic            seq_halted,
  output logic [31:0]     perf_fetch_count
);

  localparam logic [3:0] BUB_INIT = 4'(FLUSH_BUBBLES - 1);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      bub_q, bub_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            xfer;

  assign xfer = (state_q == SEQ_RUN) && s2ft_readyin;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bub_d   = bub_q;
    cnt_d   = cnt_q + {31'd0, xfer};
    if (state_q == SEQ_RESET) begin
      state_d = halt_req ? SEQ_HALT : SEQ_RUN;
    end else if (pipe_flush) begin
      // A same-cycle transfer is still counted above; its pc increment is dropped.
      pc_d    = flush_virtpc;
      bub_d   = BUB_INIT;
      state_d = halt_req ? SEQ_HALT : SEQ_BUBBLE;
    end else begin
      case (state_q)
        SEQ_RUN: begin
          if (xfer) pc_d = pc_q + 28'd1;
          if (halt_req) state_d = SEQ_HALT;
        end
        SEQ_BUBBLE: begin
          if (halt_req) state_d = SEQ_HALT;
          else if (bub_q == 4'd0) state_d = SEQ_RUN;
          else bub_d = bub_q - 4'd1;
        end
        SEQ_HALT: begin
          if (!halt_req) state_d = SEQ_RUN;
        end
        default: state_d = SEQ_RESET;
      endcase
    end
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      state_q <= SEQ_RESET;
      pc_q    <= RESET_VPC;
      bub_q   <= 4'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bub_q   <= bub_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s2ft_readyout    = (state_q == SEQ_RUN);
  assign seq_halted       = (state_q == SEQ_HALT);
  assign s2ft_out_virtpc  = pc_q;
  assign perf_fetch_count = cnt_q;

endmodule

// File: tb/tb_mcpu_core_fetch_seq.sv
// Bench for mcpu_core_fetch_seq: two instances (1 and 3 flush bubbles) driven
// together, checked by a vector table, hand sequences and a reference model.
module tb_mcpu_core_fetch_seq;

  localparam logic [27:0] RV = 28'h0000100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic [27:0] tgt = '0;
  logic        halt = 1'b0;

  logic        a_ordy, b_ordy, a_hlt, b_hlt;
  logic [27:0] a_pc, b_pc;
  logic [31:0] a_cnt, b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mcpu_core_fetch_seq #(.RESET_VPC(RV), .FLUSH_BUBBLES(1)) dut_a (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .s2ft_readyout(a_ordy), .s2ft_readyin(rdy), .s2ft_out_virtpc(a_pc),
    .pipe_flush(flush), .flush_virtpc(tgt), .halt_req(halt),
    .seq_halted(a_hlt), .perf_fetch_count(a_cnt));

  mcpu_core_fetch_seq #(.RESET_VPC(RV), .FLUSH_BUBBLES(3)) dut_b (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .s2ft_readyout(b_ordy), .s2ft_readyin(rdy), .s2ft_out_virtpc(b_pc),
    .pipe_flush(flush), .flush_virtpc(tgt), .halt_req(halt),
    .seq_halted(b_hlt), .perf_fetch_count(b_cnt));

  // Reference model: "idle" is the number of silent cycles still owed after a flush.
  int          m_nb[2] = '{1, 3};
  bit          m_started[2];
  bit          m_halted[2];
  int          m_idle[2];
  logic [27:0] m_pc[2];
  logic [31:0] m_cnt[2];

  function automatic bit m_offer(int k);
    return m_started[k] && !m_halted[k] && m_idle[k] == 0;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_started[k] = 0; m_halted[k] = 0; m_idle[k] = 0;
        m_pc[k] = RV; m_cnt[k] = 0;
      end else if (!m_started[k]) begin
        m_started[k] = 1;
        m_halted[k]  = halt;
      end else begin
        bit took;
        took = m_offer(k) && rdy;
        if (took) m_cnt[k] = m_cnt[k] + 1;
        if (flush) begin
          m_pc[k]     = tgt;
          m_halted[k] = halt;
          m_idle[k]   = halt ? 0 : m_nb[k];
        end else if (m_halted[k]) begin
          m_halted[k] = halt;
        end else if (m_idle[k] > 0) begin
          if (halt) begin m_halted[k] = 1; m_idle[k] = 0; end
          else m_idle[k] = m_idle[k] - 1;
        end else begin
          if (took) m_pc[k] = m_pc[k] + 28'd1;
          if (halt) m_halted[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("a_readyout", {31'd0, a_ordy}, {31'd0, m_offer(0)});
    chk("a_virtpc",   {4'd0, a_pc},    {4'd0, m_pc[0]});
    chk("a_halted",   {31'd0, a_hlt},  {31'd0, m_halted[0]});
    chk("a_count",    a_cnt,           m_cnt[0]);
    chk("b_readyout", {31'd0, b_ordy}, {31'd0, m_offer(1)});
    chk("b_virtpc",   {4'd0, b_pc},    {4'd0, m_pc[1]});
    chk("b_halted",   {31'd0, b_hlt},  {31'd0, m_halted[1]});
    chk("b_count",    b_cnt,           m_cnt[1]);
  endtask

  // Inputs change at negedge; the DUT and model both see them at the next posedge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(logic r, logic y, logic f, logic [27:0] t, logic h);
    rst_n = r; rdy = y; flush = f; tgt = t; halt = h;
  endtask

  typedef struct {
    logic        rst_n, rdy, flush;
    logic [27:0] tgt;
    logic        halt;
    logic        ordy;
    logic [27:0] opc;
    logic        ohlt;
    logic [31:0] ocnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int halt_left;
    // Expected outputs of the FLUSH_BUBBLES=1 instance after each edge.
    vecs.push_back('{0,1,0,28'h0,0,       0,28'h0000100,0,0});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000100,0,0});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000101,0,1});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000102,0,2});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000103,0,3});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000104,0,4});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000105,0,5});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1,0,0,28'h0,0,     1,28'h0000105,0,5});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000106,0,6});
    vecs.push_back('{1,1,0,28'h0,1,       0,28'h0000107,1,7});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1,1,0,28'h0,1,     0,28'h0000107,1,7});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000107,0,7});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000108,0,8});
    vecs.push_back('{1,1,1,28'hFFFFFFE,0, 0,28'hFFFFFFE,0,9});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'hFFFFFFE,0,9});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'hFFFFFFF,0,10});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000000,0,11});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000001,0,12});
    vecs.push_back('{1,1,1,28'h0003000,1, 0,28'h0003000,1,13});
    vecs.push_back('{1,1,0,28'h0,1,       0,28'h0003000,1,13});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0003000,0,13});
    vecs.push_back('{1,0,0,28'h0,0,       1,28'h0003000,0,13});
    vecs.push_back('{0,1,0,28'h0,0,       0,28'h0000100,0,0});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000100,0,0});
    vecs.push_back('{1,1,0,28'h0,0,       1,28'h0000101,0,1});
    vecs.push_back('{1,0,1,28'h0000500,0, 0,28'h0000500,0,1});
    vecs.push_back('{0,0,0,28'h0,0,       0,28'h0000100,0,0});
    vecs.push_back('{1,0,0,28'h0,0,       1,28'h0000100,0,0});
    vecs.push_back('{1,0,0,28'h0,1,       0,28'h0000100,1,0});
    vecs.push_back('{0,0,0,28'h0,1,       0,28'h0000100,0,0});
    vecs.push_back('{1,0,0,28'h0,1,       0,28'h0000100,1,0});
    vecs.push_back('{1,0,0,28'h0,0,       1,28'h0000100,0,0});
    vecs.push_back('{0,0,0,28'h0,0,       0,28'h0000100,0,0});
    vecs.push_back('{1,0,1,28'h0000777,0, 1,28'h0000100,0,0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].rdy, vecs[i].flush, vecs[i].tgt, vecs[i].halt);
      cycle();
      chk($sformatf("vec%0d_readyout", i), {31'd0, a_ordy}, {31'd0, vecs[i].ordy});
      chk($sformatf("vec%0d_virtpc", i),   {4'd0, a_pc},    {4'd0, vecs[i].opc});
      chk($sformatf("vec%0d_halted", i),   {31'd0, a_hlt},  {31'd0, vecs[i].ohlt});
      chk($sformatf("vec%0d_count", i),    a_cnt,           vecs[i].ocnt);
    end

    // Three-bubble instance: flush+transfer, then a re-flush inside the bubbles.
    drive(0, 0, 0, '0, 0); cycle();
    drive(1, 0, 0, '0, 0); cycle();
    drive(1, 0, 1, 28'h0000200, 0); cycle();
    chk("b3_idle0", {31'd0, b_ordy}, 32'd0);
    drive(1, 0, 0, '0, 0);
    for (int i = 1; i < 3; i++) begin
      cycle();
      chk($sformatf("b3_idle%0d", i), {31'd0, b_ordy}, 32'd0);
    end
    cycle();
    chk("b3_offer200_rdy", {31'd0, b_ordy}, 32'd1);
    chk("b3_offer200_pc", {4'd0, b_pc}, 32'h200);
    drive(1, 1, 1, 28'h0008000, 0); cycle();
    chk("b3_fx_count", b_cnt, 32'd1);
    chk("b3_fx_pc", {4'd0, b_pc}, 32'h8000);
    chk("b3_fx_rdy", {31'd0, b_ordy}, 32'd0);
    drive(1, 1, 1, 28'h0009000, 0); cycle();
    chk("b3_reflush_pc", {4'd0, b_pc}, 32'h9000);
    drive(1, 1, 0, '0, 0);
    for (int i = 1; i < 3; i++) begin
      cycle();
      chk($sformatf("b3_reidle%0d", i), {31'd0, b_ordy}, 32'd0);
    end
    cycle();
    chk("b3_offer9000_rdy", {31'd0, b_ordy}, 32'd1);
    chk("b3_offer9000_pc", {4'd0, b_pc}, 32'h9000);
    cycle();
    chk("b3_after9000_pc", {4'd0, b_pc}, 32'h9001);
    chk("b3_after9000_cnt", b_cnt, 32'd2);

    // Random traffic against the model.
    halt_left = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [27:0] t;
      logic        h;
      t = ($urandom_range(3) == 0) ? 28'(28'hFFFFFFC + 28'($urandom_range(3))) : 28'($urandom);
      if (halt_left > 0) halt_left--;
      else if ($urandom_range(19) == 0) halt_left = $urandom_range(6, 1);
      h = (halt_left > 0);
      drive(($urandom_range(199) != 0), ($urandom_range(3) != 0),
            ($urandom_range(15) == 0), t, h);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
